// File: rtl/acc_mac_pkg.sv
// Shared constants and types for the custom-0 MAC accelerator responder.
// Opcode, funct3 encodings and FSM states.
package acc_mac_pkg;

  localparam logic [6:0] OPCODE_CUSTOM0 = 7'b0001011;

  typedef enum logic [2:0] {
    F3_MAC  = 3'b000,
    F3_MUL  = 3'b001,
    F3_ADD3 = 3'b010
  } f3_e;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

endpackage

// File: rtl/acc_mac_resp_fifo.sv
// In-order response queue; the head entry drives the response channel.
// Elements are whatever packed response type the parent passes in.
module acc_mac_resp_fifo #(
  parameter type T     = logic,
  parameter int  Depth = 2,
  localparam int CntW  = $clog2(Depth + 1),
  localparam int PtrW  = (Depth > 1) ? $clog2(Depth) : 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            push_i,
  input  T                din_i,
  input  logic            pop_i,
  output logic            full_o,
  output logic            empty_o,
  output logic [CntW-1:0] count_o,
  output T                head_o
);

  T                r_mem [Depth];
  logic [PtrW-1:0] r_wr;
  logic [PtrW-1:0] r_rd;
  logic [CntW-1:0] r_cnt;

  function automatic logic [PtrW-1:0] inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
      for (int i = 0; i < Depth; i++) r_mem[i] <= '0;
    end else begin
      if (push_i) begin
        r_mem[r_wr] <= din_i;
        r_wr        <= inc(r_wr);
      end
      if (pop_i) r_rd <= inc(r_rd);
      if (push_i && !pop_i)      r_cnt <= r_cnt + 1'b1;
      else if (!push_i && pop_i) r_cnt <= r_cnt - 1'b1;
    end
  end

  assign empty_o = (r_cnt == '0);
  assign full_o  = (r_cnt == CntW'(Depth));
  assign count_o = r_cnt;
  assign head_o  = r_mem[r_rd];

endmodule

// File: rtl/acc_mac_responder.sv
// Accelerator endpoint: decodes custom-0 ops, runs ADD3 in one cycle and
// MUL/MAC on a bit-serial shift-add datapath, answering in order with the ID.
module acc_mac_responder
  import acc_mac_pkg::*;
#(
  parameter int                 DataWidth = 32,
  parameter int                 AddrWidth = 5,
  parameter int                 IdWidth   = 4,
  parameter logic [AddrWidth-1:0] AccAddr = '0,
  parameter int                 RespDepth = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [AddrWidth-1:0] q_addr_i,
  input  logic [31:0]          q_data_op_i,
  input  logic [DataWidth-1:0] q_data_arga_i,
  input  logic [DataWidth-1:0] q_data_argb_i,
  input  logic [DataWidth-1:0] q_data_argc_i,
  input  logic [IdWidth-1:0]   q_id_i,
  input  logic                 q_valid_i,
  output logic                 q_ready_o,
  output logic [DataWidth-1:0] p_data_o,
  output logic [IdWidth-1:0]   p_id_o,
  output logic                 p_error_o,
  output logic                 p_valid_o,
  input  logic                 p_ready_i
);

  localparam int CntW  = $clog2(DataWidth);
  localparam int FCntW = $clog2(RespDepth + 1);

  typedef struct packed {
    logic [DataWidth-1:0] data;
    logic [IdWidth-1:0]   id;
    logic                 error;
  } resp_t;

  state_e               r_state;
  state_e               w_state_nxt;
  logic [DataWidth-1:0] r_a;
  logic [DataWidth-1:0] r_b;
  logic [DataWidth-1:0] r_acc;
  logic [IdWidth-1:0]   r_id;
  logic [CntW-1:0]      r_cnt;

  logic                 w_f3_ok;
  logic                 w_is_mac;
  logic                 w_is_add3;
  logic                 w_legal;
  logic                 w_q_fire;
  logic                 w_start;
  logic                 w_push;
  resp_t                w_push_d;
  logic                 w_pop;
  logic                 w_full;
  logic                 w_empty;
  logic [FCntW-1:0]     w_count;
  resp_t                w_head;
  logic [DataWidth-1:0] w_acc_nxt;
  f3_e                  w_f3;

  assign w_f3 = f3_e'(q_data_op_i[14:12]);

  always_comb begin
    w_f3_ok   = 1'b0;
    w_is_mac  = 1'b0;
    w_is_add3 = 1'b0;
    unique case (1'b1)
      (w_f3 == F3_MAC):  begin w_f3_ok = 1'b1; w_is_mac  = 1'b1; end
      (w_f3 == F3_MUL):  w_f3_ok = 1'b1;
      (w_f3 == F3_ADD3): begin w_f3_ok = 1'b1; w_is_add3 = 1'b1; end
      default: ;
    endcase
  end

  assign w_legal = (q_addr_i == AccAddr)
                && (q_data_op_i[6:0] == OPCODE_CUSTOM0)
                && w_f3_ok;

  assign q_ready_o = (r_state == IDLE) && !w_full
                  && (w_count < FCntW'(RespDepth));
  assign w_q_fire  = q_valid_i && q_ready_o;
  assign w_acc_nxt = r_b[0] ? r_acc + r_a : r_acc;

  always_comb begin
    w_state_nxt = r_state;
    w_push      = 1'b0;
    w_push_d    = '0;
    w_start     = 1'b0;
    unique case (r_state)
      IDLE: if (w_q_fire) begin
        if (!w_legal) begin
          w_push         = 1'b1;
          w_push_d.id    = q_id_i;
          w_push_d.error = 1'b1;
        end else if (w_is_add3) begin
          w_push        = 1'b1;
          w_push_d.data = q_data_arga_i + q_data_argb_i + q_data_argc_i;
          w_push_d.id   = q_id_i;
        end else begin
          w_start     = 1'b1;
          w_state_nxt = BUSY;
        end
      end
      BUSY: if (r_cnt == '0) begin
        w_push        = 1'b1;
        w_push_d.data = w_acc_nxt;
        w_push_d.id   = r_id;
        w_state_nxt   = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_a   <= '0;
      r_b   <= '0;
      r_acc <= '0;
      r_id  <= '0;
      r_cnt <= '0;
    end else if (w_start) begin
      r_a   <= q_data_arga_i;
      r_b   <= q_data_argb_i;
      r_acc <= w_is_mac ? q_data_argc_i : '0;
      r_id  <= q_id_i;
      r_cnt <= CntW'(DataWidth - 1);
    end else if (r_state == BUSY) begin
      r_acc <= w_acc_nxt;
      r_a   <= r_a << 1;
      r_b   <= r_b >> 1;
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign w_pop = p_valid_o && p_ready_i;

  acc_mac_resp_fifo #(
    .T     (resp_t),
    .Depth (RespDepth)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (w_push),
    .din_i   (w_push_d),
    .pop_i   (w_pop),
    .full_o  (w_full),
    .empty_o (w_empty),
    .count_o (w_count),
    .head_o  (w_head)
  );

  assign p_valid_o = !w_empty;
  assign p_data_o  = w_empty ? '0 : w_head.data;
  assign p_id_o    = w_empty ? '0 : w_head.id;
  assign p_error_o = w_empty ? 1'b0 : w_head.error;

endmodule
